// File: rtl/tcdm_bank_arbiter.sv
// rtl/tcdm_bank_arbiter.sv - round-robin arbiter sharing one TCDM bank port among NumIn requesters
module tcdm_bank_arbiter #(
    parameter int unsigned NumIn        = 4,
    parameter int unsigned AddrMemWidth = 10,
    parameter int unsigned DataWidth    = 32,
    parameter bit          WriteRespOn  = 1'b0
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumIn-1:0]                req_i,
    input  logic [NumIn*AddrMemWidth-1:0]   add_i,
    input  logic [NumIn-1:0]                wen_i,
    input  logic [NumIn*DataWidth-1:0]      wdata_i,
    input  logic [NumIn*(DataWidth/8)-1:0]  be_i,
    output logic [NumIn-1:0]                gnt_o,
    output logic [NumIn-1:0]                vld_o,
    output logic [DataWidth-1:0]            rdata_o,
    output logic                            mem_req_o,
    input  logic                            mem_gnt_i,
    output logic [AddrMemWidth-1:0]         mem_addr_o,
    output logic                            mem_wen_o,
    output logic [DataWidth-1:0]            mem_wdata_o,
    output logic [DataWidth/8-1:0]          mem_be_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = (NumIn > 1) ? $clog2(NumIn) : 1;

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] rr_next;
    logic            resp_vld_q;
    logic [IdxW-1:0] resp_idx_q;

    logic [IdxW-1:0] win;
    logic            found;
    logic [IdxW:0]   pos;
    logic            handshake;

    // Scan from the pointer with an explicit wrap so non-power-of-2 NumIn works.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            pos = {1'b0, rr_q} + (IdxW+1)'(k);
            if (pos >= (IdxW+1)'(NumIn)) begin
                pos = pos - (IdxW+1)'(NumIn);
            end
            if (!found && req_i[pos[IdxW-1:0]]) begin
                found = 1'b1;
                win   = pos[IdxW-1:0];
            end
        end
    end

    // Gating with rst_ni keeps the bank and grants quiet while reset is held.
    assign mem_req_o = found & rst_ni;
    assign handshake = mem_req_o & mem_gnt_i;

    always_comb begin
        mem_addr_o  = '0;
        mem_wen_o   = 1'b0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (mem_req_o) begin
            mem_addr_o  = add_i[win*AddrMemWidth +: AddrMemWidth];
            mem_wen_o   = wen_i[win];
            mem_wdata_o = wdata_i[win*DataWidth +: DataWidth];
            mem_be_o    = be_i[win*BeWidth +: BeWidth];
        end
    end

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[win] = 1'b1;
        end
    end

    assign rr_next = (win == IdxW'(NumIn - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            resp_vld_q <= 1'b0;
            resp_idx_q <= '0;
        end else if (handshake) begin
            rr_q       <= rr_next;
            resp_vld_q <= ~mem_wen_o | WriteRespOn;
            resp_idx_q <= win;
        end else begin
            resp_vld_q <= 1'b0;
        end
    end

    // Bank read data arrives one cycle after acceptance, so it is forwarded as is.
    always_comb begin
        vld_o = '0;
        if (resp_vld_q) begin
            vld_o[resp_idx_q] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata_i;

    a_num_in: assert property (@(posedge clk_i) NumIn >= 2);
    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
    a_vld_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vld_o));
    a_gnt_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);

endmodule

// File: doc/tcdm_bank_arbiter.md
Name: tcdm_bank_arbiter

Overview:
- Round-robin arbiter that shares one TCDM bank port between NumIn requesters, e.g. local cores and remote interconnect ports within a tile.
- Sits between the interconnect/core-side master ports and one SRAM bank.
- Handles request selection, the grant handshake and read-response routing for a bank with fixed 1-cycle read latency.
- Guarantees starvation-free, fair access.

Parameters:
- NumIn, 4, number of requesters; must be ≥2.
- AddrMemWidth, 10, bank-local word address width.
- DataWidth, 32, data width; the byte-enable width is DataWidth/8.
- WriteRespOn, 0, when 1 a write also returns a vld_o pulse; when 0 writes produce no response.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_i  in  NumIn  per-requester request.
- add_i  in  NumIn×AddrMemWidth  per-requester word address.
- wen_i  in  NumIn  per-requester write enable (1 = write).
- wdata_i  in  NumIn×DataWidth  per-requester write data.
- be_i  in  NumIn×DataWidth/8  per-requester byte enables.
- gnt_o  out  NumIn  grant, one-hot or zero.
- vld_o  out  NumIn  response valid, one-hot or zero.
- rdata_o  out  DataWidth  response data, shared by all requesters.
- mem_req_o  out  1  bank request.
- mem_gnt_i  in  1  bank accepts the request this cycle.
- mem_addr_o  out  AddrMemWidth  bank address.
- mem_wen_o  out  1  bank write enable.
- mem_wdata_o  out  DataWidth  bank write data.
- mem_be_o  out  DataWidth/8  bank byte enables.
- mem_rdata_i  in  DataWidth  bank read data, valid 1 cycle after an accepted request.

Behaviour:
- State:
  - rr_q: round-robin pointer, $clog2(NumIn) bits.
  - resp_vld_q: response pending flag.
  - resp_idx_q: response target index.
  - Reset values: rr_q=0, resp_vld_q=0, resp_idx_q=0.
- Reset values of outputs: gnt_o=0, vld_o=0, mem_req_o=0, rdata_o=mem_rdata_i (don't-care). Outputs are combinational from state and inputs, so they take these values while rst_ni=0.
- Arbitration (combinational, same cycle):
  - The winner w is the first index i with req_i[i]=1, scanning rr_q, rr_q+1, …, NumIn-1, 0, …, rr_q-1.
  - mem_req_o = |req_i.
  - mem_addr_o, mem_wen_o, mem_wdata_o and mem_be_o carry requester w's fields. When no request is present they are zero.
- Grant:
  - gnt_o[w] = mem_req_o & mem_gnt_i. All other gnt_o bits are 0.
  - A requester holds req_i and its payload stable until granted. The arbiter does not rely on this but must not glitch grant on payload changes.
- Pointer update (on a handshake only):
  - On rising edge with a handshake (mem_req_o & mem_gnt_i): rr_q <= (w==NumIn-1) ? 0 : w+1. The wrap-around is explicit, with no reliance on power-of-2 NumIn.
  - No handshake: rr_q holds, even if requests are present but mem_gnt_i=0.
- Response path, 1-cycle latency:
  - On a handshake: resp_vld_q <= (~mem_wen_o | WriteRespOn) and resp_idx_q <= w.
  - Otherwise: resp_vld_q <= 0.
  - vld_o[resp_idx_q] = resp_vld_q. rdata_o = mem_rdata_i, passed through unregistered.
- Simultaneous events:
  - A grant to a new request may occur in the same cycle as the response to the previous one. Back-to-back throughput is one transaction per cycle.
  - The same requester may win consecutively only if it is the sole requester.
- Fairness bound: with all NumIn requesting and mem_gnt_i=1, each requester is granted exactly once in every NumIn consecutive cycles.
- Reset mid-operation: a pending response is dropped (vld_o=0 immediately) and rr_q returns to 0. No grant is issued while rst_ni=0.
- Assertions (simulation only):
  - gnt_o is one-hot or zero.
  - vld_o is one-hot or zero.
  - No gnt_o without the matching req_i.
  - NumIn ≥ 2.

Test Plan:
- Reset then idle: rst_ni=0 for 3 cycles, all req_i=0 → gnt_o=0, vld_o=0, mem_req_o=0. Release reset, first request from 2 → granted immediately (rr_q=0, scan reaches 2).
- Full contention: NumIn=4, req_i=4'b1111 held, mem_gnt_i=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3; vld_o follows one cycle later in the same order for reads.
- Bank stall: req_i=4'b0110, mem_gnt_i=0 for 3 cycles then 1 → gnt_o=0 while stalled and rr_q stays 0. First grant goes to 1, next cycle to 2.
- Read routing: requester 3 reads addr 0x05, bank returns 0xDEADBEEF next cycle → vld_o=4'b1000 and rdata_o=0xDEADBEEF exactly 1 cycle after gnt_o[3].
- Write response: requester 1 writes with be=4'b0011.
  - WriteRespOn=0 → mem_be_o=0011 and no vld_o pulse.
  - WriteRespOn=1 → vld_o=4'b0010 one cycle later.
- Reset mid-operation: grant a read to requester 2, assert rst_ni=0 in the next cycle → vld_o=0 that cycle. After release, contention on 4'b1111 is granted starting at 0.
